shift_univ: RTL and testbench

- Parametrised universal shift register; successor to the fixed 5-bit serial-in shift block.
- Generalised in lane width (DATA_W bits per stage) and depth (DEPTH stages).
- Adds per-cycle mode select: hold, shift left/right, rotate left/right, parallel load, clear.
- Tracks fill count and shifted-out element. Used as serialiser/deserialiser and delay line in datapath front-ends.

---
 rtl/shift_univ_pkg.sv | 17 +
 rtl/shift_fill_cnt.sv | 40 ++++
 rtl/shift_univ.sv | 122 ++++++++++++
 tb/tb_shift_univ.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/shift_univ_pkg.sv
// Shared mode encoding for the universal shift register.
package shift_univ_pkg;

  localparam int MODE_W = 3;

  typedef enum logic [MODE_W-1:0] {
    MODE_HOLD  = 3'd0,
    MODE_SHL   = 3'd1,
    MODE_SHR   = 3'd2,
    MODE_ROTL  = 3'd3,
    MODE_ROTR  = 3'd4,
    MODE_LOAD  = 3'd5,
    MODE_CLEAR = 3'd6,
    MODE_RSVD  = 3'd7
  } mode_e;

endpackage

// File: rtl/shift_fill_cnt.sv
// Saturating fill counter 0..DEPTH; clr beats set_full beats inc.
// Registered output, one-cycle update, never decrements.
module shift_fill_cnt #(
  parameter int DEPTH = 5,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             inc_i,
  input  logic             set_full_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (set_full_i) begin
      cnt_d = FULL_CNT;
    end else if (inc_i && (cnt_q != FULL_CNT)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/shift_univ.sv
// Universal shift register: hold/shift/rotate/load/clear over DEPTH lanes of DATA_W bits.
// SHIFT_UNIV_PARITY_EN adds a contents parity output and a sticky load-parity error flag.
module shift_univ
  import shift_univ_pkg::*;
#(
  parameter int DATA_W = 1,
  parameter int DEPTH = 5,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [MODE_W-1:0]       mode_i,
  input  logic [DATA_W-1:0]       data_i,
  input  logic [DEPTH*DATA_W-1:0] load_i,
  output logic [DEPTH*DATA_W-1:0] data_o,
  output logic [DATA_W-1:0]       serial_o,
  output logic [CNT_W-1:0]        cnt_o,
  output logic                    full_o
`ifdef SHIFT_UNIV_PARITY_EN
  ,
  input  logic                    load_par_i,
  output logic                    parity_o,
  output logic                    parity_err_o
`endif
);

  localparam int W = DEPTH * DATA_W;

  mode_e             mode;
  logic [W-1:0]      data_q, data_d;
  logic [DATA_W-1:0] serial_q, serial_d;
  logic              cnt_inc, cnt_set_full, cnt_clr;

  assign mode = mode_e'(mode_i);

  // Stage 0 sits in the least significant slice, so "left" moves toward the MSBs.
  always_comb begin
    data_d       = data_q;
    serial_d     = serial_q;
    cnt_inc      = 1'b0;
    cnt_set_full = 1'b0;
    cnt_clr      = 1'b0;
    case (mode)
      MODE_SHL: begin
        data_d   = {data_q[W-DATA_W-1:0], data_i};
        serial_d = data_q[W-1 -: DATA_W];
        cnt_inc  = 1'b1;
      end
      MODE_SHR: begin
        data_d   = {data_i, data_q[W-1:DATA_W]};
        serial_d = data_q[DATA_W-1:0];
        cnt_inc  = 1'b1;
      end
      MODE_ROTL: data_d = {data_q[W-DATA_W-1:0], data_q[W-1 -: DATA_W]};
      MODE_ROTR: data_d = {data_q[DATA_W-1:0], data_q[W-1:DATA_W]};
      MODE_LOAD: begin
        data_d       = load_i;
        cnt_set_full = 1'b1;
      end
      MODE_CLEAR: begin
        data_d   = '0;
        serial_d = '0;
        cnt_clr  = 1'b1;
      end
      default: begin
        data_d   = data_q;
        serial_d = serial_q;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      data_q   <= '0;
      serial_q <= '0;
    end else begin
      data_q   <= data_d;
      serial_q <= serial_d;
    end
  end

  shift_fill_cnt #(
    .DEPTH(DEPTH)
  ) u_fill_cnt (
    .clock     (clock),
    .reset_n   (reset_n),
    .inc_i     (cnt_inc),
    .set_full_i(cnt_set_full),
    .clr_i     (cnt_clr),
    .cnt_o     (cnt_o)
  );

  assign data_o   = data_q;
  assign serial_o = serial_q;
  assign full_o   = (cnt_o == CNT_W'(DEPTH));

`ifdef SHIFT_UNIV_PARITY_EN
  logic parity_err_q, parity_err_d;

  // Sticky: only CLEAR or reset drops the flag, a later good LOAD does not.
  always_comb begin
    parity_err_d = parity_err_q;
    if (mode == MODE_CLEAR) begin
      parity_err_d = 1'b0;
    end else if ((mode == MODE_LOAD) && ((^load_i) != load_par_i)) begin
      parity_err_d = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      parity_err_q <= 1'b0;
    end else begin
      parity_err_q <= parity_err_d;
    end
  end

  assign parity_o     = ^data_q;
  assign parity_err_o = parity_err_q;
`endif

endmodule

// File: tb/tb_shift_univ.sv
// Scoreboard bench for shift_univ: a 1x5 instance and an 8x4 instance on one clock.
module tb_shift_univ;
  import shift_univ_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic [2:0]  mode_a, mode_b;
  logic        din_a;
  logic [7:0]  din_b;
  logic [4:0]  load_a, data_a;
  logic [31:0] load_b, data_b;
  logic        ser_a;
  logic [7:0]  ser_b;
  logic [2:0]  cnt_a, cnt_b;
  logic        full_a, full_b;
`ifdef SHIFT_UNIV_PARITY_EN
  logic        lpar_a, lpar_b, par_a, par_b, perr_a, perr_b;
`endif

  shift_univ #(.DATA_W(1), .DEPTH(5)) u_dut_a (
    .clock(clk), .reset_n(reset_n), .mode_i(mode_a), .data_i(din_a), .load_i(load_a),
    .data_o(data_a), .serial_o(ser_a), .cnt_o(cnt_a), .full_o(full_a)
`ifdef SHIFT_UNIV_PARITY_EN
    , .load_par_i(lpar_a), .parity_o(par_a), .parity_err_o(perr_a)
`endif
  );

  shift_univ #(.DATA_W(8), .DEPTH(4)) u_dut_b (
    .clock(clk), .reset_n(reset_n), .mode_i(mode_b), .data_i(din_b), .load_i(load_b),
    .data_o(data_b), .serial_o(ser_b), .cnt_o(cnt_b), .full_o(full_b)
`ifdef SHIFT_UNIV_PARITY_EN
    , .load_par_i(lpar_b), .parity_o(par_b), .parity_err_o(perr_b)
`endif
  );

  typedef struct {
    string       name;
    int          unit;
    logic [31:0] data;
    logic [7:0]  ser;
    int          cnt;
    logic        full;
    logic        perr;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic strobe   = 1'b0;
  logic exp_perr_a = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: drains the scoreboard on each falling edge, or on demand for async checks.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk or posedge strobe);
      while (q.size() > 0) begin
        e = q.pop_front();
        if (e.unit == 0) begin
          chk({e.name, ".data"}, {27'b0, data_a}, e.data);
          chk({e.name, ".serial"}, {31'b0, ser_a}, {24'b0, e.ser});
          chk({e.name, ".cnt"}, {29'b0, cnt_a}, 32'(e.cnt));
          chk({e.name, ".full"}, {31'b0, full_a}, {31'b0, e.full});
`ifdef SHIFT_UNIV_PARITY_EN
          chk({e.name, ".parity"}, {31'b0, par_a}, {31'b0, ^e.data});
          chk({e.name, ".perr"}, {31'b0, perr_a}, {31'b0, e.perr});
`endif
        end else begin
          chk({e.name, ".data"}, data_b, e.data);
          chk({e.name, ".serial"}, {24'b0, ser_b}, {24'b0, e.ser});
          chk({e.name, ".cnt"}, {29'b0, cnt_b}, 32'(e.cnt));
          chk({e.name, ".full"}, {31'b0, full_b}, {31'b0, e.full});
`ifdef SHIFT_UNIV_PARITY_EN
          chk({e.name, ".parity"}, {31'b0, par_b}, {31'b0, ^e.data});
          chk({e.name, ".perr"}, {31'b0, perr_b}, 32'b0);
`endif
        end
      end
    end
  end

  task automatic op_a(input string nm, input logic [2:0] m, input logic d, input logic [4:0] ld,
                      input logic [4:0] ed, input logic es, input int ec);
    exp_t e;
    @(negedge clk);
    mode_a = m;
    din_a  = d;
    load_a = ld;
    @(posedge clk);
    #1;
    mode_a = 3'd0;
    e = '{nm, 0, {27'b0, ed}, {7'b0, es}, ec, (ec == 5), exp_perr_a};
    q.push_back(e);
  endtask

  task automatic op_b(input string nm, input logic [2:0] m, input logic [7:0] d, input logic [31:0] ld,
                      input logic [31:0] ed, input logic [7:0] es, input int ec);
    exp_t e;
    @(negedge clk);
    mode_b = m;
    din_b  = d;
    load_b = ld;
    @(posedge clk);
    #1;
    mode_b = 3'd0;
    e = '{nm, 1, ed, es, ec, (ec == 4), 1'b0};
    q.push_back(e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at time %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t e;
    reset_n = 1'b0;
    mode_a = 3'd0; mode_b = 3'd0;
    din_a = 1'b0; din_b = 8'h00;
    load_a = '0; load_b = '0;
`ifdef SHIFT_UNIV_PARITY_EN
    lpar_a = 1'b1; lpar_b = 1'b0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // Fill with ones past saturation, then reset mid-cycle with no edge.
    op_a("shl1_1", 3'd1, 1'b1, 5'b0, 5'b00001, 1'b0, 1);
    op_a("shl1_2", 3'd1, 1'b1, 5'b0, 5'b00011, 1'b0, 2);
    op_a("shl1_3", 3'd1, 1'b1, 5'b0, 5'b00111, 1'b0, 3);
    op_a("shl1_4", 3'd1, 1'b1, 5'b0, 5'b01111, 1'b0, 4);
    op_a("shl1_5", 3'd1, 1'b1, 5'b0, 5'b11111, 1'b0, 5);
    op_a("shl1_6", 3'd1, 1'b1, 5'b0, 5'b11111, 1'b1, 5);
    @(negedge clk);
    #1 reset_n = 1'b0;
    #1;
    e = '{"async_rst", 0, 32'h0, 8'h0, 0, 1'b0, 1'b0};
    q.push_back(e);
    strobe = 1'b1;
    #1 strobe = 1'b0;
    reset_n = 1'b1;

    op_a("shl_a", 3'd1, 1'b1, 5'b0, 5'b00001, 1'b0, 1);
    op_a("shl_b", 3'd1, 1'b0, 5'b0, 5'b00010, 1'b0, 2);
    op_a("shl_c", 3'd1, 1'b1, 5'b0, 5'b00101, 1'b0, 3);
    op_a("shl_d", 3'd1, 1'b1, 5'b0, 5'b01011, 1'b0, 4);
    op_a("shl_e", 3'd1, 1'b0, 5'b0, 5'b10110, 1'b0, 5);
    op_a("shl_sat", 3'd1, 1'b1, 5'b0, 5'b01101, 1'b1, 5);

    op_a("clr_a", 3'd6, 1'b0, 5'b0, 5'b00000, 1'b0, 0);
    op_a("load_a", 3'd5, 1'b0, 5'b10011, 5'b10011, 1'b0, 5);
    op_a("shr_a", 3'd2, 1'b0, 5'b0, 5'b01001, 1'b1, 5);

    op_a("load_r", 3'd5, 1'b1, 5'b10011, 5'b10011, 1'b1, 5);
    op_a("rotl_1", 3'd3, 1'b1, 5'b0, 5'b00111, 1'b1, 5);
    op_a("rotl_2", 3'd3, 1'b0, 5'b0, 5'b01110, 1'b1, 5);
    op_a("rotr_1", 3'd4, 1'b1, 5'b0, 5'b00111, 1'b1, 5);
    op_a("hold_a", 3'd0, 1'b0, 5'b11111, 5'b00111, 1'b1, 5);
    op_a("rsvd_a", 3'd7, 1'b1, 5'b11111, 5'b00111, 1'b1, 5);

    op_a("clr_b", 3'd6, 1'b1, 5'b0, 5'b00000, 1'b0, 0);
    op_a("shl_p", 3'd1, 1'b1, 5'b0, 5'b00001, 1'b0, 1);
    op_a("rotr_p", 3'd4, 1'b0, 5'b0, 5'b10000, 1'b0, 1);
    op_a("rotl_p", 3'd3, 1'b0, 5'b0, 5'b00001, 1'b0, 1);

    // Bad load parity: flag rises after the LOAD and survives a good LOAD.
`ifdef SHIFT_UNIV_PARITY_EN
    lpar_a = 1'b0;
`endif
    exp_perr_a = 1'b1;
    op_a("load_bad", 3'd5, 1'b0, 5'b10011, 5'b10011, 1'b0, 5);
`ifdef SHIFT_UNIV_PARITY_EN
    lpar_a = 1'b1;
`endif
    op_a("shl_err", 3'd1, 1'b0, 5'b0, 5'b00110, 1'b1, 5);
    op_a("load_ok", 3'd5, 1'b0, 5'b10011, 5'b10011, 1'b1, 5);
    exp_perr_a = 1'b0;
    op_a("clr_err", 3'd6, 1'b0, 5'b0, 5'b00000, 1'b0, 0);

    op_b("w_load", 3'd5, 8'h00, 32'h44332211, 32'h44332211, 8'h00, 4);
    op_b("w_rsvd", 3'd7, 8'hFF, 32'h0, 32'h44332211, 8'h00, 4);
    op_b("w_clr", 3'd6, 8'h00, 32'h0, 32'h00000000, 8'h00, 0);
    op_b("w_load2", 3'd5, 8'h00, 32'h44332211, 32'h44332211, 8'h00, 4);
    op_b("w_shr", 3'd2, 8'hAA, 32'h0, 32'hAA443322, 8'h11, 4);
    op_b("w_shl", 3'd1, 8'h55, 32'h0, 32'h44332255, 8'hAA, 4);
    op_b("w_rotr", 3'd4, 8'h00, 32'h0, 32'h55443322, 8'hAA, 4);
    op_b("w_clr2", 3'd6, 8'h00, 32'h0, 32'h00000000, 8'h00, 0);
    op_b("w_shl1", 3'd1, 8'h77, 32'h0, 32'h00000077, 8'h00, 1);

    repeat (3) @(negedge clk);
    if (q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d entries left, required 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
